idli_trace_m: RTL and testbench
===============================

Name: idli_trace_m

Overview:
- Synthesisable retirement-trace unit for the bit-serial idli core.
- Reassembles the serially delivered PC from SLICE_W-wide slices and timestamps each completed instruction. Each record also carries the predicate state.
- Records are buffered in a DEPTH-entry FIFO and drained over a valid/ready port by an on-chip debug bridge or the bench.
- Replaces ad-hoc probing with a width- and depth-parametrised block that has overflow accounting.

Parameters:
- DATA_W, 16: PC width; must be a multiple of SLICE_W.
- SLICE_W, 4: bits of PC delivered per cycle.
- DEPTH, 8: FIFO entries; power of two, at least 2.
- TS_W, 16: timestamp counter width.
- PC_ADJ, 1: pipeline offset subtracted from the reassembled PC, modulo 2^DATA_W.

Ports:
- i_trc_gck  in  1  clock; single clock domain.
- i_trc_rst_n  in  1  reset; synchronous, active-low.
- i_trc_en  in  1  capture enable.
- i_trc_clr  in  1  synchronous flush of FIFO, overflow flag, drop count and timestamp.
- i_trc_pc  in  SLICE_W  PC slice presented this cycle, LSB slice first.
- i_trc_done  in  1  instruction completes this cycle; the current slice is the final one.
- i_trc_preds  in  3  predicate registers P0..P2, values being written this cycle.
- o_trc_valid  out  1  record available.
- i_trc_ready  in  1  consumer accepts the record.
- o_trc_data  out  DATA_W+4+TS_W  record {ts, preds[3:0], pc}; pc in the LSBs.
- o_trc_level  out  $clog2(DEPTH)+1  entries held.
- o_trc_ovf  out  1  sticky: at least one record was dropped.
- o_trc_drops  out  8  saturating dropped-record count.

Behaviour:
- Reset (i_trc_rst_n low at a clock edge):
  - all outputs 0;
  - PC shift register and timestamp 0;
  - FIFO empty.
- PC shift register: pc_q updates every cycle, regardless of i_trc_en.
  - pc_d = {i_trc_pc, pc_q[DATA_W-1:SLICE_W]}.
  - Captured pc = pc_d - PC_ADJ; wraps modulo 2^DATA_W. Example: pc_d 0x0000 with PC_ADJ 1 gives 0xFFFF.
- Timestamp: free-running ts_q, incremented every cycle and wrapping at 2^TS_W. The record captures ts_q of the i_trc_done cycle.
- Predicates: record preds = {1'b1, i_trc_preds}. P3 is hard-wired true.
- Push:
  - condition: i_trc_done & i_trc_en & ~i_trc_clr;
  - record is written on that edge;
  - o_trc_valid rises the following cycle (latency 1); no bypass from done to output.
- Pop: o_trc_valid & i_trc_ready at an edge. o_trc_data always shows the head entry and is stable while valid is high and ready is low.
- Full with push and pop in the same cycle: both succeed and the level is unchanged.
- Full with push and no pop:
  - record is dropped and FIFO contents are unchanged;
  - o_trc_ovf is set;
  - o_trc_drops increments, saturating at 255.
- Empty with push: the record is written and o_trc_valid is 1 next cycle. A pop cannot occur in that cycle.
- o_trc_level equals writes minus reads; range 0..DEPTH.
- i_trc_clr:
  - on the next edge: FIFO empty, ovf 0, drops 0, ts_q 0;
  - takes priority over push and pop in the same cycle;
  - pc_q is not cleared.
- i_trc_en low suppresses pushes only. Draining continues.
- FIFO pointers are $clog2(DEPTH)+1 bits wide. The wrap bit distinguishes full from empty.

Decomposition:
- idli_pkg gains:
  - defaults IDLI_TRC_DEPTH = 8 and IDLI_TRC_TS_W = 16;
  - trc_entry_t packed struct {ts[15:0], preds[3:0], pc[15:0]} for default widths, for bench decoding.
- Sub-module idli_trace_fifo_m: generic synchronous FIFO with push, pop, full, empty and level, parametrised on WIDTH and DEPTH.
- idli_trace_m holds:
  - PC reassembly;
  - timestamp;
  - overflow and drop counters;
  - push gating.

Test Plan:
- PC reassembly and push. Release reset at ts=0, ready=1. Drive slices 5,3,2,1 with done on the slice-1 cycle (ts=3); preds=3'b101.
  - Next cycle valid=1 and data = {ts=0x0003, preds=4'b1101, pc=0x1234}.
  - Level drops 1 to 0 on the accept edge.
- Wrap. Drive pc_d=0x0000 with done. Captured pc is 0xFFFF.
- Overflow. Hold ready=0 and issue 10 dones.
  - level=8, ovf=1, drops=2.
  - Draining yields the first 8 records in order.
- Full with simultaneous push and pop. Reach level 8, then ready=1 with done.
  - Level stays 8 and drops stays 0.
  - The new record appears after the 7 older ones.
- Clear priority. Reach level 3 with drops=1, then assert clr together with done and ready.
  - Next cycle: level=0, valid=0, ovf=0, drops=0, ts restarts at 0.
- Enable and reset mid-stream.
  - en=0 with done: no push.
  - Reset asserted at level 5: next cycle all outputs 0.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared definitions for the idli retirement-trace block.
//   IDLI_TRC_DEPTH / IDLI_TRC_TS_W : default FIFO depth and timestamp width.
//   trc_entry_t : record layout at default widths ({ts, preds, pc}, pc in
//                 the LSBs), used to decode o_trc_data.
package idli_pkg;

    localparam int IDLI_TRC_DEPTH = 8;
    localparam int IDLI_TRC_TS_W  = 16;

    typedef struct packed {
        logic [15:0] ts;
        logic [3:0]  preds;
        logic [15:0] pc;
    } trc_entry_t;

endpackage

// File: rtl/idli_trace_m_if.sv
// Bundle of the trace unit's capture inputs and record drain port.
//   master : core / debug side (drives capture inputs and ready)
//   slave  : trace unit (drives valid, data, level, ovf, drops)
interface idli_trace_m_if #(
    parameter int DATA_W  = 16,
    parameter int SLICE_W = 4,
    parameter int DEPTH   = 8,
    parameter int TS_W    = 16
);
    logic                       i_trc_en;
    logic                       i_trc_clr;
    logic [SLICE_W-1:0]         i_trc_pc;
    logic                       i_trc_done;
    logic [2:0]                 i_trc_preds;
    logic                       o_trc_valid;
    logic                       i_trc_ready;
    logic [DATA_W+4+TS_W-1:0]   o_trc_data;
    logic [$clog2(DEPTH):0]     o_trc_level;
    logic                       o_trc_ovf;
    logic [7:0]                 o_trc_drops;

    modport master (
        output i_trc_en, i_trc_clr, i_trc_pc, i_trc_done, i_trc_preds, i_trc_ready,
        input  o_trc_valid, o_trc_data, o_trc_level, o_trc_ovf, o_trc_drops
    );

    modport slave (
        input  i_trc_en, i_trc_clr, i_trc_pc, i_trc_done, i_trc_preds, i_trc_ready,
        output o_trc_valid, o_trc_data, o_trc_level, o_trc_ovf, o_trc_drops
    );

endinterface

// File: rtl/idli_trace_fifo_m.sv
// Generic synchronous FIFO.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous flush, wins over push/pop
//   push/wdata : write request; ignored when full unless a pop happens too
//   pop        : read request; ignored when empty
//   rdata      : head entry (undefined while empty)
//   full, empty, level : occupancy status
module idli_trace_fifo_m #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop_en;
    logic             wr_en;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level  = wr_ptr - rd_ptr;
    assign rdata  = mem[rd_ptr[AW-1:0]];

    // When full, a same-cycle pop frees the head slot, which the write reuses.
    assign pop_en = pop & ~empty;
    assign wr_en  = push & (~full | pop_en);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
            if (pop_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !clr && wr_en)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/idli_trace_m.sv
// Retirement-trace unit for the bit-serial idli core.
// Reassembles the PC from LSB-first slices, stamps each completed
// instruction with a free-running timestamp and the predicate state, and
// queues records for a valid/ready consumer. Records arriving while the
// queue is full are dropped and counted.
//   i_trc_gck, i_trc_rst_n : clock, synchronous active-low reset
//   trc (slave)            : capture inputs, drain handshake, level/ovf/drops
module idli_trace_m
    import idli_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int SLICE_W = 4,
    parameter int DEPTH   = IDLI_TRC_DEPTH,
    parameter int TS_W    = IDLI_TRC_TS_W,
    parameter int PC_ADJ  = 1
) (
    input  logic            i_trc_gck,
    input  logic            i_trc_rst_n,
    idli_trace_m_if.slave   trc
);
    localparam int REC_W = DATA_W + 4 + TS_W;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    // Only the upper DATA_W-SLICE_W bits of the shift register are ever
    // read back (the low slice falls off on the next shift), so only those
    // are stored.
    logic [DATA_W-SLICE_W-1:0] pc_q;
    logic [DATA_W-1:0]         pc_d;
    logic [DATA_W-1:0]         pc_cap;
    logic [TS_W-1:0]           ts_q;
    logic [REC_W-1:0]          rec;
    logic [REC_W-1:0]          head;
    logic                      push;
    logic                      pop;
    logic                      full;
    logic                      empty;
    logic [LVL_W-1:0]          level;
    logic                      drop;
    logic                      ovf_q;
    logic [7:0]                drops_q;

    assign pc_d   = {trc.i_trc_pc, pc_q};
    assign pc_cap = pc_d - DATA_W'(PC_ADJ);
    assign rec    = {ts_q, 1'b1, trc.i_trc_preds, pc_cap};

    always_ff @(posedge i_trc_gck) begin
        if (!i_trc_rst_n) pc_q <= '0;
        else              pc_q <= pc_d[DATA_W-1:SLICE_W];
    end

    always_ff @(posedge i_trc_gck) begin
        if (!i_trc_rst_n || trc.i_trc_clr) ts_q <= '0;
        else                               ts_q <= ts_q + 1'b1;
    end

    assign push = trc.i_trc_done & trc.i_trc_en & ~trc.i_trc_clr;
    assign pop  = ~empty & trc.i_trc_ready & ~trc.i_trc_clr;
    assign drop = push & full & ~pop;

    idli_trace_fifo_m #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_trc_gck),
        .rst_n (i_trc_rst_n),
        .clr   (trc.i_trc_clr),
        .push  (push),
        .pop   (pop),
        .wdata (rec),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge i_trc_gck) begin
        if (!i_trc_rst_n || trc.i_trc_clr) begin
            ovf_q   <= 1'b0;
            drops_q <= '0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (drops_q != 8'hFF) drops_q <= drops_q + 1'b1;
        end
    end

    // FIFO storage is not reset; mask the head so an empty queue reads 0.
    assign trc.o_trc_valid = ~empty;
    assign trc.o_trc_data  = empty ? '0 : head;
    assign trc.o_trc_level = level;
    assign trc.o_trc_ovf   = ovf_q;
    assign trc.o_trc_drops = drops_q;

endmodule

// File: tb/tb_idli_trace_m.sv
module tb_idli_trace_m;
    import idli_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    idli_trace_m_if trc_if ();

    idli_trace_m dut (
        .i_trc_gck   (clk),
        .i_trc_rst_n (rst_n),
        .trc         (trc_if)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: queue of expected records plus plain counters.
    logic [35:0] m_q[$];
    int m_ts, m_ovf, m_drops;
    int s1, s2, s3;             // previous three slices, s1 most recent

    function automatic logic [35:0] mk_rec(int ts, int preds, int pc);
        longint v;
        v = longint'(ts) * 1048576 + longint'(8 + preds) * 65536 + longint'(pc);
        return v[35:0];
    endfunction

    task automatic step(input bit rst, input bit en, input bit clr, input int pc,
                        input bit done, input int preds, input bit ready);
        int pcd, cap;
        @(negedge clk);
        rst_n               = rst;
        trc_if.i_trc_en     = en;
        trc_if.i_trc_clr    = clr;
        trc_if.i_trc_pc     = 4'(pc);
        trc_if.i_trc_done   = done;
        trc_if.i_trc_preds  = 3'(preds);
        trc_if.i_trc_ready  = ready;
        @(posedge clk);
        pcd = pc * 4096 + s1 * 256 + s2 * 16 + s3;
        cap = (pcd + 65536 - 1) % 65536;
        if (!rst) begin
            m_q.delete(); m_ts = 0; m_ovf = 0; m_drops = 0;
            s1 = 0; s2 = 0; s3 = 0;
        end else begin
            if (clr) begin
                m_q.delete(); m_ovf = 0; m_drops = 0; m_ts = 0;
            end else begin
                if (m_q.size() > 0 && ready) void'(m_q.pop_front());
                if (done && en) begin
                    if (m_q.size() < 8) m_q.push_back(mk_rec(m_ts, preds, cap));
                    else begin
                        m_ovf = 1;
                        if (m_drops < 255) m_drops++;
                    end
                end
                m_ts = (m_ts + 1) % 65536;
            end
            s3 = s2; s2 = s1; s1 = pc;
        end
        #1;
        chk("valid", 64'(trc_if.o_trc_valid), 64'(m_q.size() > 0));
        chk("data",  64'(trc_if.o_trc_data),  (m_q.size() > 0) ? 64'(m_q[0]) : 64'd0);
        chk("level", 64'(trc_if.o_trc_level), 64'(m_q.size()));
        chk("ovf",   64'(trc_if.o_trc_ovf),   64'(m_ovf));
        chk("drops", 64'(trc_if.o_trc_drops), 64'(m_drops));
    endtask

    task automatic idle(input bit ready);
        step(1, 1, 0, int'($urandom_range(0, 15)), 0, int'($urandom_range(0, 7)), ready);
    endtask

    task automatic done_n(input int n, input bit ready);
        for (int i = 0; i < n; i++)
            step(1, 1, 0, int'($urandom_range(0, 15)), 1, int'($urandom_range(0, 7)), ready);
    endtask

    trc_entry_t e;

    initial begin
        rst_n = 1'b0;
        trc_if.i_trc_en = 0; trc_if.i_trc_clr = 0; trc_if.i_trc_pc = 0;
        trc_if.i_trc_done = 0; trc_if.i_trc_preds = 0; trc_if.i_trc_ready = 0;
        s1 = 0; s2 = 0; s3 = 0; m_ts = 0; m_ovf = 0; m_drops = 0;

        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // PC reassembly: slices 5,3,2,1 -> 0x1235, minus 1 -> 0x1234, ts 3
        step(1, 1, 0, 5, 0, 0, 1);
        step(1, 1, 0, 3, 0, 0, 1);
        step(1, 1, 0, 2, 0, 0, 1);
        step(1, 1, 0, 1, 1, 3'b101, 1);
        e = trc_entry_t'(trc_if.o_trc_data);
        chk("t1_valid", 64'(trc_if.o_trc_valid), 64'd1);
        chk("t1_ts",    64'(e.ts),    64'h0003);
        chk("t1_preds", 64'(e.preds), 64'b1101);
        chk("t1_pc",    64'(e.pc),    64'h1234);
        chk("t1_lvl",   64'(trc_if.o_trc_level), 64'd1);
        idle(1);
        chk("t1_lvl_pop", 64'(trc_if.o_trc_level), 64'd0);

        // Wrap: pc_d 0x0000 -> captured 0xFFFF
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 2, 0);
        e = trc_entry_t'(trc_if.o_trc_data);
        chk("wrap_pc", 64'(e.pc), 64'hFFFF);
        idle(1);

        // Overflow: 10 dones into 8 entries
        done_n(10, 0);
        chk("ovf_lvl",   64'(trc_if.o_trc_level), 64'd8);
        chk("ovf_flag",  64'(trc_if.o_trc_ovf),   64'd1);
        chk("ovf_drops", 64'(trc_if.o_trc_drops), 64'd2);
        for (int i = 0; i < 8; i++) idle(1);
        chk("ovf_drain", 64'(trc_if.o_trc_level), 64'd0);

        // Full with simultaneous push and pop
        step(1, 1, 1, 0, 0, 0, 0);
        done_n(8, 0);
        done_n(1, 1);
        chk("fpp_lvl",   64'(trc_if.o_trc_level), 64'd8);
        chk("fpp_drops", 64'(trc_if.o_trc_drops), 64'd0);
        for (int i = 0; i < 8; i++) idle(1);

        // Clear priority at level 3, drops 1
        done_n(9, 0);
        for (int i = 0; i < 5; i++) idle(1);
        chk("clr_pre_lvl",   64'(trc_if.o_trc_level), 64'd3);
        chk("clr_pre_drops", 64'(trc_if.o_trc_drops), 64'd1);
        step(1, 1, 1, 7, 1, 5, 1);
        chk("clr_lvl",   64'(trc_if.o_trc_level), 64'd0);
        chk("clr_valid", 64'(trc_if.o_trc_valid), 64'd0);
        chk("clr_ovf",   64'(trc_if.o_trc_ovf),   64'd0);
        chk("clr_drops", 64'(trc_if.o_trc_drops), 64'd0);
        done_n(1, 0);
        e = trc_entry_t'(trc_if.o_trc_data);
        chk("clr_ts0", 64'(e.ts), 64'd0);

        // Enable low suppresses pushes
        step(1, 0, 0, 9, 1, 1, 0);
        chk("en_lvl", 64'(trc_if.o_trc_level), 64'd1);

        // Reset at level 5
        done_n(4, 0);
        chk("rst_pre_lvl", 64'(trc_if.o_trc_level), 64'd5);
        step(0, 1, 0, 3, 1, 7, 0);
        chk("rst_valid", 64'(trc_if.o_trc_valid), 64'd0);
        chk("rst_data",  64'(trc_if.o_trc_data),  64'd0);
        chk("rst_lvl",   64'(trc_if.o_trc_level), 64'd0);
        chk("rst_ovf",   64'(trc_if.o_trc_ovf),   64'd0);
        chk("rst_drops", 64'(trc_if.o_trc_drops), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 49) == 0, int'($urandom_range(0, 15)),
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                 $urandom_range(0, 2) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
